// File: rtl/frame_router_ctrl.sv
// Serial frame parser that routes payload bits to a 1-to-4 demux.
// Frame: start, addr[1:0], len, len+1 payload bits, even parity.
module frame_router_ctrl #(
    parameter int LEN_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_in,
    input  logic       s_valid,
    output logic [1:0] d_sel,
    output logic       d_in,
    output logic       d_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        PARITY
    } state_t;

    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(LEN_W - 1);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_sh;
    logic             r_a1;
    logic             r_par;
    logic [1:0]       r_dsel;
    logic             r_din;
    logic             r_dvalid;
    logic             r_done;
    logic             r_err;
    logic             w_din;
    logic             w_dvalid;
    logic             w_done;
    logic             w_err;
    logic             w_last;

    assign w_len_sh = (r_len << 1) | LEN_W'(s_in);
    assign w_last   = (r_cnt == '0);

    // State, counters, parity and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_a1     <= 1'b0;
            r_par    <= 1'b0;
            r_dsel   <= 2'd0;
            r_din    <= 1'b0;
            r_dvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_din    <= w_din;
            r_dvalid <= w_dvalid;
            r_done   <= w_done;
            r_err    <= w_err;
            if (s_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (s_in) begin
                            r_cnt <= ONE;
                            r_par <= 1'b0;
                        end
                    end
                    ADDR: begin
                        r_par <= r_par ^ s_in;
                        if (w_last) begin
                            r_dsel <= {r_a1, s_in};
                            r_cnt  <= LEN_LAST;
                        end else begin
                            r_a1  <= s_in;
                            r_cnt <= r_cnt - ONE;
                        end
                    end
                    LEN: begin
                        r_par <= r_par ^ s_in;
                        r_len <= w_len_sh;
                        // Remaining-bit count: len means len+1 payload bits
                        r_cnt <= w_last ? w_len_sh : r_cnt - ONE;
                    end
                    DATA: begin
                        r_par <= r_par ^ s_in;
                        r_cnt <= r_cnt - ONE;
                    end
                    PARITY: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (s_valid) begin
            unique case (r_state)
                IDLE:    if (s_in) w_next = ADDR;
                ADDR:    if (w_last) w_next = LEN;
                LEN:     if (w_last) w_next = DATA;
                DATA:    if (w_last) w_next = PARITY;
                PARITY:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_din    = 1'b0;
        w_dvalid = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        busy     = (r_state != IDLE);
        if (s_valid) begin
            if (r_state == DATA) begin
                w_dvalid = 1'b1;
                w_din    = s_in;
            end
            if (r_state == PARITY) begin
                w_done = 1'b1;
                w_err  = r_par ^ s_in;
            end
        end
    end

    assign d_sel      = r_dsel;
    assign d_in       = r_din;
    assign d_valid    = r_dvalid;
    assign frame_done = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_frame_router_ctrl.sv
// Scoreboard bench for frame_router_ctrl: driver queues expected
// pulses, monitor pops and compares on every DUT output pulse.
module tb_frame_router_ctrl;

    localparam int LEN_W = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_in = 1'b0;
    logic       s_valid = 1'b0;
    logic [1:0] d_sel;
    logic       d_in;
    logic       d_valid;
    logic       busy;
    logic       frame_done;
    logic       err;

    frame_router_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk),
        .reset(reset),
        .s_in(s_in),
        .s_valid(s_valid),
        .d_sel(d_sel),
        .d_in(d_in),
        .d_valid(d_valid),
        .busy(busy),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit       done;
        bit       din;
        bit       e;
        bit [1:0] sel;
    } ev_t;

    ev_t      q[$];
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    bit       mon_en = 1'b0;
    bit       exp_busy = 1'b0;
    bit [1:0] exp_sel = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                     name, cyc, act, req);
        end
    endtask

    // Monitor: compares every sampled cycle against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, exp_busy);
            chk("d_sel_hold", d_sel, exp_sel);
            if (!d_valid) chk("d_in_idle_zero", d_in, 0);
            if (d_valid || frame_done || err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("frame_done", frame_done, e.done);
                    chk("d_valid", d_valid, !e.done);
                    chk("err", err, e.e);
                    if (!e.done) begin
                        chk("d_in", d_in, e.din);
                        chk("d_sel", d_sel, e.sel);
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("missing_pulse", cyc, q[0].cyc + 1000);
                void'(q.pop_front());
            end
        end
    end

    task automatic drive(input bit b, input bit v);
        s_in    = b;
        s_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset   = 1'b1;
        s_valid = 1'($urandom_range(0, 1));
        s_in    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        s_valid  = 1'b0;
        exp_busy = 1'b0;
        exp_sel  = 2'd0;
    endtask

    // Reference model: frame built as a bit list; parity from field popcount
    task automatic send_frame(input bit [1:0] a, input int len,
                              input bit [7:0] pay, input bit flip,
                              input int gapmax, input int abort_at);
        bit bq[$];
        bit par;
        int n;
        bq.push_back(1'b1);
        bq.push_back(a[1]);
        bq.push_back(a[0]);
        for (int i = LEN_W - 1; i >= 0; i--) bq.push_back(len[i]);
        for (int i = 0; i <= len; i++) bq.push_back(pay[i]);
        par = 1'b0;
        for (int i = 1; i < bq.size(); i++) par ^= bq[i];
        bq.push_back(par ^ flip);
        n = bq.size();
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                pulse_reset();
                return;
            end
            if (k > 0) begin
                repeat ($urandom_range(0, gapmax))
                    drive(1'($urandom_range(0, 1)), 1'b0);
            end
            drive(bq[k], 1'b1);
            if (k == 0) exp_busy = 1'b1;
            if (k == 2) exp_sel = a;
            if (k >= 3 + LEN_W && k < n - 1)
                q.push_back('{cyc, 1'b0, bq[k], 1'b0, a});
            if (k == n - 1) begin
                bit odd;
                odd = 1'b0;
                for (int i = 1; i < n; i++) odd ^= bq[i];
                q.push_back('{cyc, 1'b1, 1'b0, odd, a});
                exp_busy = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_d_sel", d_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        repeat (5) drive(1'b0, 1'b1);
        // addr=2 len=2 payload 1,0,1 good and bad parity
        send_frame(2'd2, 2, 8'b101, 1'b0, 0, -1);
        send_frame(2'd2, 2, 8'b101, 1'b1, 0, -1);
        repeat (2) drive(1'b0, 1'b0);
        send_frame(2'd2, 2, 8'b101, 1'b0, 3, -1);
        // max length, then back-to-back addr 0
        send_frame(2'd3, 7, 8'b1011_0110, 1'b0, 0, -1);
        send_frame(2'd0, 1, 8'b01, 1'b0, 0, -1);
        // reset during payload, then a clean frame
        send_frame(2'd2, 2, 8'b101, 1'b0, 0, 7);
        @(negedge clk);
        chk("abort_d_sel", d_sel, 0);
        chk("abort_valid", d_valid, 0);
        send_frame(2'd2, 2, 8'b101, 1'b0, 0, -1);
        for (int f = 0; f < 40; f++) begin
            int ab;
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : -1;
            send_frame(2'($urandom_range(0, 3)), $urandom_range(0, 7),
                       8'($urandom), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), ab);
            repeat ($urandom_range(0, 2))
                drive(1'b0, 1'($urandom_range(0, 1)));
        end
        repeat (4) drive(1'b0, 1'b0);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_router_ctrl.md
FRAME_ROUTER_CTRL -- requirements
Module: frame_router_ctrl

Interface
REQ-001 Parameter LEN_W, default 3: width of the frame length field; payload is 1..2^LEN_W bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 s_in  input  1  serial frame bit.
REQ-005 s_valid  input  1  s_in carries a bit this cycle; bits are consumed only when s_valid=1.
REQ-006 d_sel  output  2  registered output-port select for the downstream 1-to-4 demux.
REQ-007 d_in  output  1  registered payload bit for the downstream demux.
REQ-008 d_valid  output  1  one-cycle pulse; d_in holds a payload bit.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 frame_done  output  1  one-cycle pulse at frame end.
REQ-011 err  output  1  one-cycle pulse, coincident with frame_done, on parity mismatch.

Function
REQ-012 Frame format, MSB first: start bit (1), addr[1:0], len[LEN_W-1:0], payload of len+1 bits, then the parity bit.
REQ-013 Parity is even over addr, len and payload; the parity bit makes the total count of ones in those fields plus the parity bit even.
REQ-014 FSM states: IDLE, ADDR, LEN, DATA, PARITY; transitions occur only on cycles with s_valid=1.
REQ-015 IDLE: s_valid=1 with s_in=1 -> ADDR; s_valid=1 with s_in=0 is ignored and the FSM stays in IDLE.
REQ-016 ADDR: after 2 consumed bits -> LEN; d_sel loads the assembled addr on the clock edge that consumes the second addr bit.
REQ-017 LEN: after LEN_W consumed bits -> DATA; the payload counter loads len.
REQ-018 DATA: each consumed bit -> d_in=s_in and d_valid=1 on the next cycle; after len+1 bits -> PARITY.
REQ-019 PARITY: the consumed bit is checked -> frame_done=1 on the next cycle, err=1 if parity is odd, FSM -> IDLE.
REQ-020 Latency: d_valid, frame_done and err are asserted exactly 1 cycle after the s_valid cycle that produced them.
REQ-021 d_in=0 whenever d_valid=0, so every downstream demux output is 0 between payload bits.
REQ-022 d_sel holds its value between frames and changes only per REQ-016.
REQ-023 s_valid=0 mid-frame: state, counters and parity accumulator hold; no output pulses.
REQ-024 A start bit arriving in the cycle that frame_done is asserted is accepted, so back-to-back frames have no dead cycle.
REQ-025 A maximum-length payload (len all ones, 2^LEN_W bits) is handled without counter wrap error.
REQ-026 An err frame is not retracted: payload bits already output stand, and only err flags the failure.

Reset
REQ-027 While reset=1 at a clock edge: FSM -> IDLE, all counters and the parity accumulator cleared, d_sel=0, d_in=0, d_valid=0, busy=0, frame_done=0, err=0.
REQ-028 Reset takes priority over s_valid in the same cycle.
REQ-029 Reset mid-frame discards the partial frame without asserting frame_done or err.

Verification
REQ-030 Reset, then idle zeros with s_valid=1 -> busy stays 0 and every output stays 0.
REQ-031 LEN_W=3, bits 1,1,0,0,1,0,1,0,1,0 (addr=2, len=2, payload 1,0,1, parity 0) -> d_sel=2, three d_valid pulses with d_in 1,0,1, then frame_done=1 and err=0.
REQ-032 Same frame with the parity bit set to 1 -> same payload output, frame_done=1 and err=1.
REQ-033 Same frame with s_valid deasserted for 3 cycles between every bit -> identical outputs, each pulse 1 cycle after its consuming bit, busy high throughout the frame.
REQ-034 addr=3 with len=7 (8 payload bits), immediately followed by an addr=0 frame -> 8 d_valid pulses at d_sel=3, then d_sel=0 with no dead cycle.
REQ-035 reset=1 pulsed during DATA of the REQ-031 frame -> all outputs 0, no frame_done; the next full frame is routed correctly.
